// File: rtl/uart_tx_slave_pkg.sv
// Slave-bus command/result types and the UART register map, status bit positions and
// transmitter state encoding.
package MemoryBus;
    typedef struct packed {
        logic [7:0]  address;
        logic [31:0] write_data;
        logic [3:0]  mask_byte;
        logic        mem_read;
        logic        mem_write;
    } Cmd;

    typedef logic [31:0] Result;
endpackage

package UartPkg;
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    // A zero-length bit would stall the down-counters, so zero is stored as one.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction
endpackage

// File: rtl/uart_tx_slave_if.sv
// Bundle of the slave-bus command and read-data signals for the UART register window.
interface uart_tx_slave_if;
    import MemoryBus::*;

    Cmd    membuscmd;
    Result membusres;

    modport master (output membuscmd, input membusres);
    modport slave  (input membuscmd, output membusres);
endinterface

// File: rtl/uart_tx_slave_fifo.sv
// Synchronous FIFO with first-word fall-through output; a push to a full FIFO is
// accepted only when a pop happens in the same cycle.
module SyncFifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/uart_tx_slave.sv
// Bus-programmed UART transmitter: byte FIFO, programmable bit length, 8N1 framing.
// state   | meaning
// IDLE    | line high; pops the FIFO head and latches the bit length when data waits
// START   | start bit (low) for bit_len clocks
// DATA    | eight data bits, LSB first, bit_len clocks each
// STOP    | stop bit (high) for bit_len clocks, then back to IDLE
module uart_tx_slave
    import UartPkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic             clk,
    input  logic             rst,
    input  MemoryBus::Cmd    membuscmd,
    output MemoryBus::Result membusres,
    output logic             tx,
    output logic             irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    sel;
    logic          wr_txdata, ovf_clr, wr_divisor;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          busy;
    logic          unused_bits;

    tx_state_e     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   bit_len_q, bit_len_d;
    logic [15:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;

    assign sel        = membuscmd.address[1:0];
    assign wr_txdata  = membuscmd.mem_write && (sel == REG_TXDATA) && membuscmd.mask_byte[0];
    assign ovf_clr    = membuscmd.mem_write && (sel == REG_STATUS) && membuscmd.mask_byte[0]
                        && membuscmd.write_data[3];
    assign wr_divisor = membuscmd.mem_write && (sel == REG_DIVISOR);
    assign busy       = (state_q != ST_IDLE);
    assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
    assign tx         = tx_q;
    assign irq        = fifo_empty && !busy;

    assign unused_bits = ^{membuscmd.address[7:2], membuscmd.write_data[31:16],
                           membuscmd.mask_byte[3:2], fifo_count};

    SyncFifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (membuscmd.write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        membusres = '0;
        if (membuscmd.mem_read) begin
            case (sel)
                REG_STATUS: begin
                    membusres[STAT_FULL]  = fifo_full;
                    membusres[STAT_EMPTY] = fifo_empty;
                    membusres[STAT_BUSY]  = busy;
                    membusres[STAT_OVF]   = ovf_q;
                end
                REG_DIVISOR:          membusres = {16'b0, div_q};
                REG_TXDATA, REG_RSVD: membusres = '0;
                default:              membusres = '0;
            endcase
        end
    end

    always_comb begin
        div_d = div_q;
        if (wr_divisor) begin
            div_d = clamp_div({membuscmd.mask_byte[1] ? membuscmd.write_data[15:8] : div_q[15:8],
                               membuscmd.mask_byte[0] ? membuscmd.write_data[7:0]  : div_q[7:0]});
        end
        // A drop in the same cycle as a clear wins, so the lost byte is never hidden.
        ovf_d = (ovf_q && !ovf_clr) || (wr_txdata && fifo_full && !fifo_pop);

        state_d   = state_q;
        shift_d   = shift_q;
        bit_len_d = bit_len_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    shift_d   = fifo_dout;
                    bit_len_d = div_q;
                    bit_cnt_d = div_q - 16'd1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_cnt_q == 16'd0) begin
                    bit_cnt_d = bit_len_q - 16'd1;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_cnt_q == 16'd0) begin
                    bit_cnt_d = bit_len_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The line is registered from the current state, so it trails the state by one clock.
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            div_q     <= DEFAULT_DIV;
            bit_len_q <= DEFAULT_DIV;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            div_q     <= div_d;
            bit_len_q <= bit_len_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_slave.sv
// Bench for uart_tx_slave: register vector table, directed frame/FIFO corner cases and
// randomized frame trains checked against the tx line history.
module tb_uart_tx_slave;
    import UartPkg::*;

    localparam logic [15:0] DEF_DIV = 16'd434;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx, irq;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   tx_hist[$];
    logic [7:0] exp_b[$];
    int   exp_d[$];

    typedef struct {
        bit          do_wr;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic [1:0]  ra;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    uart_tx_slave_if bus();

    uart_tx_slave #(.FIFO_DEPTH(8), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .membuscmd (bus.membuscmd),
        .membusres (bus.membusres),
        .tx        (tx),
        .irq       (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // tx_hist[e] is the line value sampled just after rising edge e.
    initial begin
        tx_hist.push_back(1'b1);
        forever begin
            @(negedge clk);
            tx_hist.push_back(tx);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m,
                             output int edge_no);
        bus.membuscmd.address    = {6'b0, a};
        bus.membuscmd.write_data = d;
        bus.membuscmd.mask_byte  = m;
        bus.membuscmd.mem_read   = 1'b0;
        bus.membuscmd.mem_write  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        edge_no = cyc;
        bus.membuscmd.mem_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.membuscmd.address   = {6'b0, a};
        bus.membuscmd.mem_write = 1'b0;
        bus.membuscmd.mem_read  = 1'b1;
        #1;
        d = bus.membusres;
        bus.membuscmd.mem_read = 1'b0;
    endtask

    task automatic wait_edge(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (!irq && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk({name, " idle timeout"}, irq, 1);
        repeat (20) @(negedge clk);
    endtask

    function automatic int first_low(input int from, input int to);
        for (int i = from; i <= to && i < tx_hist.size(); i++)
            if (tx_hist[i] == 1'b0) return i;
        return -1;
    endfunction

    task automatic check_frame(input string name, input int s, input logic [7:0] b, input int d);
        int errs = 0;
        logic [7:0] got = '0;
        for (int k = 0; k < 10; k++) begin
            bit eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            for (int j = 0; j < d; j++) begin
                int i = s + k * d + j;
                if (i >= tx_hist.size() || tx_hist[i] != eb) errs++;
            end
        end
        for (int k = 0; k < 8; k++) begin
            int i = s + (k + 1) * d + d / 2;
            if (i < tx_hist.size()) got[k] = tx_hist[i];
        end
        chk({name, " byte"}, got, b);
        chk({name, " bit timing errors"}, errs, 0);
    endtask

    // Frames in exp_b/exp_d are expected back to back: one idle clock between stop and start.
    task automatic check_train(input string name, input int from, input int s0);
        int s = s0;
        int f = from;
        for (int k = 0; k < exp_b.size(); k++) begin
            chk($sformatf("%s f%0d start", name, k), first_low(f, s + 4), s);
            check_frame($sformatf("%s f%0d", name, k), s, exp_b[k], exp_d[k]);
            f = s + 10 * exp_d[k];
            s = f + 1;
        end
        chk({name, " extra frame"}, first_low(f, tx_hist.size() - 1), 32'hFFFF_FFFF);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  b [10];
        int e, n0;

        bus.membuscmd = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("tx in reset", tx, 1);
        chk("irq in reset", irq, 1);
        rst = 1'b1;
        @(negedge clk);

        tbl.push_back('{0, 2'd0, 32'h0, 4'h0, REG_STATUS,  32'h2});
        tbl.push_back('{0, 2'd0, 32'h0, 4'h0, REG_DIVISOR, 32'(DEF_DIV)});
        tbl.push_back('{0, 2'd0, 32'h0, 4'h0, REG_TXDATA,  32'h0});
        tbl.push_back('{0, 2'd0, 32'h0, 4'h0, REG_RSVD,    32'h0});
        tbl.push_back('{1, REG_DIVISOR, 32'hFFFF1234, 4'b0001, REG_DIVISOR, 32'h0134});
        tbl.push_back('{1, REG_DIVISOR, 32'h0000AB00, 4'b0010, REG_DIVISOR, 32'hAB34});
        tbl.push_back('{1, REG_DIVISOR, 32'h00000000, 4'b0011, REG_DIVISOR, 32'h0001});
        tbl.push_back('{1, REG_RSVD,    32'hFFFFFFFF, 4'b1111, REG_DIVISOR, 32'h0001});
        tbl.push_back('{1, REG_TXDATA,  32'h00000055, 4'b1110, REG_STATUS,  32'h2});
        tbl.push_back('{1, REG_STATUS,  32'h00000008, 4'b0001, REG_STATUS,  32'h2});
        tbl.push_back('{1, REG_DIVISOR, 32'h00000300, 4'b0010, REG_DIVISOR, 32'h0301});
        tbl.push_back('{1, REG_DIVISOR, 32'h00000000, 4'b0001, REG_DIVISOR, 32'h0300});
        tbl.push_back('{1, REG_DIVISOR, 32'h00000004, 4'b0011, REG_DIVISOR, 32'h0004});
        tbl.push_back('{1, REG_DIVISOR, 32'h00001234, 4'b0000, REG_DIVISOR, 32'h0004});
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].do_wr) bus_write(tbl[i].wa, tbl[i].wd, tbl[i].wm, e);
            bus_read(tbl[i].ra, rd);
            chk($sformatf("vec%0d", i), rd, tbl[i].exp);
        end
        chk("irq idle", irq, 1);

        // Single 0xA5 frame at 4 clocks per bit.
        bus_write(REG_TXDATA, 32'hA5, 4'b0001, n0);
        bus_read(REG_STATUS, rd);
        chk("status before pop", rd, 32'h0);
        wait_edge(n0 + 10);
        bus_read(REG_STATUS, rd);
        chk("status mid frame", rd, 32'h6);
        chk("irq mid frame", irq, 0);
        wait_idle("a5", 200);
        exp_b = {8'hA5}; exp_d = {4};
        check_train("a5", n0, n0 + 2);

        // Ten back-to-back writes into an 8-deep FIFO while the first byte is on the line.
        for (int k = 0; k < 10; k++) begin
            b[k] = 8'($urandom);
            bus_write(REG_TXDATA, {24'b0, b[k]}, 4'b0001, e);
            if (k == 0) n0 = e;
        end
        bus_read(REG_STATUS, rd);
        chk("status overflow", rd, 32'hD);
        bus_write(REG_STATUS, 32'h8, 4'b0001, e);
        bus_read(REG_STATUS, rd);
        chk("status ovf cleared", rd, 32'h5);
        wait_idle("ovf", 600);
        exp_b.delete(); exp_d.delete();
        for (int k = 0; k < 9; k++) begin exp_b.push_back(b[k]); exp_d.push_back(4); end
        check_train("ovf", n0, n0 + 2);

        // Divisor change during DATA affects only the following frame.
        b[0] = 8'($urandom); b[1] = 8'($urandom);
        bus_write(REG_TXDATA, {24'b0, b[0]}, 4'b0001, n0);
        bus_write(REG_TXDATA, {24'b0, b[1]}, 4'b0001, e);
        wait_edge(n0 + 12);
        bus_write(REG_DIVISOR, 32'h8, 4'b0011, e);
        wait_idle("divchg", 300);
        exp_b = {b[0], b[1]}; exp_d = {4, 8};
        check_train("divchg", n0, n0 + 2);
        bus_write(REG_DIVISOR, 32'h4, 4'b0011, e);

        // Push into a full FIFO on the very edge the idle state pops.
        for (int k = 0; k < 10; k++) b[k] = 8'($urandom);
        bus_write(REG_TXDATA, {24'b0, b[0]}, 4'b0001, n0);
        for (int k = 1; k < 9; k++) bus_write(REG_TXDATA, {24'b0, b[k]}, 4'b0001, e);
        bus_read(REG_STATUS, rd);
        chk("status full busy", rd, 32'h5);
        wait_edge(n0 + 42);
        bus_read(REG_STATUS, rd);
        chk("status full idle", rd, 32'h1);
        bus_write(REG_TXDATA, {24'b0, b[9]}, 4'b0001, e);
        bus_read(REG_STATUS, rd);
        chk("status push on pop", rd, 32'h5);
        wait_idle("fullpop", 600);
        exp_b.delete(); exp_d.delete();
        for (int k = 0; k < 10; k++) begin exp_b.push_back(b[k]); exp_d.push_back(4); end
        check_train("fullpop", n0, n0 + 2);

        // Asynchronous reset in the middle of a data bit.
        bus_write(REG_TXDATA, 32'h00, 4'b0001, n0);
        bus_write(REG_TXDATA, 32'hFF, 4'b0001, e);
        wait_edge(n0 + 16);
        chk("tx before reset", tx, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("tx at reset", tx, 1);
        chk("irq at reset", irq, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        e = cyc;
        bus_read(REG_STATUS, rd);
        chk("status after reset", rd, 32'h2);
        bus_read(REG_DIVISOR, rd);
        chk("div after reset", rd, 32'(DEF_DIV));
        repeat (60) @(negedge clk);
        chk("no frame after reset", first_low(e, tx_hist.size() - 1), 32'hFFFF_FFFF);

        // Divisor zero is stored as one: single-clock bits.
        bus_write(REG_DIVISOR, 32'h0, 4'b0011, e);
        bus_read(REG_DIVISOR, rd);
        chk("div zero read", rd, 32'h1);
        bus_write(REG_TXDATA, 32'h3C, 4'b0001, n0);
        wait_idle("div1", 100);
        exp_b = {8'h3C}; exp_d = {1};
        check_train("div1", n0, n0 + 2);

        // Random trains: random divisor, 1..8 bytes written back to back.
        for (int r = 0; r < 10; r++) begin
            int d, n;
            d = int'($urandom_range(5, 1));
            n = int'($urandom_range(8, 1));
            bus_write(REG_DIVISOR, 32'(d), 4'b0011, e);
            exp_b.delete(); exp_d.delete();
            for (int k = 0; k < n; k++) begin
                logic [7:0] v;
                v = 8'($urandom);
                exp_b.push_back(v);
                exp_d.push_back(d);
                bus_write(REG_TXDATA, {24'b0, v}, 4'b0001, e);
                if (k == 0) n0 = e;
            end
            wait_idle($sformatf("rnd%0d", r), n * (10 * d + 1) + 50);
            check_train($sformatf("rnd%0d", r), n0, n0 + 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_slave.md
UART_TX_SLAVE -- requirements
Module: uart_tx_slave

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning TX FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter DEFAULT_DIV, default 16'd434, meaning reset value of DIVISOR in clocks per bit.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port membuscmd, input, MemoryBus::Cmd: slave command from the slave bus mux window (4 words).
REQ-006 SHALL have port membusres, output, MemoryBus::Result (32 bits): read data.
REQ-007 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-008 SHALL have port irq, output, 1 bit: level, high while FIFO empty and transmitter idle.

Function
REQ-009 SHALL decode register select from membuscmd.address[1:0]: 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 reserved.
REQ-010 SHALL drive membusres combinationally, same cycle as mem_read: TXDATA reads 0, STATUS {27'b0, overflow, busy, empty, full}, DIVISOR {16'b0, div}, reserved 0.
REQ-011 SHALL push write_data[7:0] into the FIFO on a clock edge with mem_write=1, select=TXDATA, mask_byte[0]=1, one push per cycle.
REQ-012 SHALL, when a push hits a full FIFO with no pop that cycle, drop the byte and set sticky overflow.
REQ-013 SHALL accept a push to a full FIFO when a pop occurs the same cycle; count unchanged.
REQ-014 SHALL clear overflow on a STATUS write with mask_byte[0]=1 and write_data[3]=1; a set and a clear in the same cycle leave overflow set.
REQ-015 SHALL update div from write_data[15:0] on a DIVISOR write, with mask_byte[0] gating bits 7:0 and mask_byte[1] gating bits 15:8; a written value of 0 is stored as 1.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-017 SHALL, in IDLE with FIFO non-empty, pop the head byte into the shift register, latch div into bit_len, and enter START on the next edge.
REQ-018 SHALL hold each bit for exactly bit_len clocks: tx=0 in START; data LSB first over 8 bits in DATA; tx=1 in STOP; then return to IDLE.
REQ-019 SHALL keep a DIVISOR change made mid-frame from affecting the current frame; it takes effect at the next pop.
REQ-020 SHALL start the next frame back-to-back: STOP to IDLE, pop on the IDLE cycle, so only 1 extra idle-high clock separates frames.
REQ-021 SHALL time a write to an empty idle FIFO at edge N as: pop at edge N+1, tx falls at edge N+2.
REQ-022 SHALL assert busy in any state other than IDLE; empty and full reflect the FIFO count after the last edge.
REQ-023 SHALL use a 16-bit bit counter and a 3-bit bit index, with no wrap outside their stated ranges.
REQ-024 SHALL ignore writes to the reserved register and ignore mask_byte[3:1] on TXDATA.

Reset
REQ-025 SHALL, while rst=0 (asynchronous), force tx=1, FSM=IDLE, FIFO empty, overflow=0, div=DEFAULT_DIV, and irq=1.
REQ-026 SHALL abort a frame when reset asserts mid-frame: tx high immediately, and FIFO contents lost.

Structure
REQ-027 SHALL place register offsets, STATUS bit indices and the FSM state enum in shared package UartPkg.
REQ-028 SHALL instantiate a single sub-module SyncFifo (parameters WIDTH=8 and DEPTH), providing push, pop, full, empty and count.

Verification
REQ-029 SHALL cover: div=4, write 0xA5 -> tx pattern 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks, first falling edge 2 clocks after the write.
REQ-030 SHALL cover: FIFO_DEPTH=8, 10 back-to-back writes while the first byte transmits -> 9 bytes sent, overflow=1, and a STATUS write of 0x8 clears it.
REQ-031 SHALL cover: DIVISOR written to 8 during the DATA state of a div=4 frame -> remaining bits still take 4 clocks and the next frame uses 8 clocks per bit.
REQ-032 SHALL cover: push while full in the same cycle as an IDLE pop -> byte accepted, full stays 1, no overflow.
REQ-033 SHALL cover: rst asserted in the middle of the DATA state -> tx=1 the same cycle, STATUS reads 0x2 after release, and no further frame is sent.
REQ-034 SHALL cover: DIVISOR write of 0 -> reads back 1, and bits are 1 clock long.
